// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle main controller:
//   - opcode constants decoded from the instruction register
//   - ALUOp class codes (also consumed by the ALU controller)
//   - ALUSrcB and PCSource mux encodings
//   - controller state enum and the packed control word
// ----------------------------------------------------------------------------
package ctrl_pkg;

    // Opcode field values
    localparam logic [5:0] OP_R     = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // ALUOp class codes; code 0 is reserved and never driven
    localparam logic [2:0] ALUOP_BNE   = 3'd1;
    localparam logic [2:0] ALUOP_R     = 3'd2;
    localparam logic [2:0] ALUOP_ADD   = 3'd3;
    localparam logic [2:0] ALUOP_SLTIU = 3'd4;
    localparam logic [2:0] ALUOP_BEQ   = 3'd5;
    localparam logic [2:0] ALUOP_LUI   = 3'd6;
    localparam logic [2:0] ALUOP_ORI   = 3'd7;

    // ALU B-operand mux
    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        I_EXEC    = 4'd8,
        I_WB      = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       memto_reg;
        logic [1:0] pc_source;
        logic       pc_en;
        logic       illegal;
    } ctrl_t;

    // States whose exit to FETCH completes an instruction
    function automatic logic is_retiring(input state_t s);
        return (s == MEM_WB) || (s == MEM_WRITE) || (s == R_WB) ||
               (s == I_WB)   || (s == BRANCH)    || (s == JUMP);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Bundle between the main controller and the datapath.
//   master : controller side (reads opcode/ready/zero, drives control word)
//   slave  : datapath side
// ----------------------------------------------------------------------------
interface mc_ctrl_fsm_if #(
    parameter int RETIRE_W = 32
);
    logic [5:0]          instr_op_i;
    logic                mem_ready_i;
    logic                zero_i;
    logic [2:0]          ALUOp_o;
    logic                ALUSrcA_o;
    logic [1:0]          ALUSrcB_o;
    logic                IorD_o;
    logic                MemRead_o;
    logic                MemWrite_o;
    logic                IRWrite_o;
    logic                RegWrite_o;
    logic                RegDst_o;
    logic                MemtoReg_o;
    logic [1:0]          PCSource_o;
    logic                pc_en_o;
    logic                illegal_o;
    logic [3:0]          state_o;
    logic [RETIRE_W-1:0] retired_o;

    modport master (
        input  instr_op_i, mem_ready_i, zero_i,
        output ALUOp_o, ALUSrcA_o, ALUSrcB_o, IorD_o, MemRead_o, MemWrite_o,
               IRWrite_o, RegWrite_o, RegDst_o, MemtoReg_o, PCSource_o,
               pc_en_o, illegal_o, state_o, retired_o
    );

    modport slave (
        output instr_op_i, mem_ready_i, zero_i,
        input  ALUOp_o, ALUSrcA_o, ALUSrcB_o, IorD_o, MemRead_o, MemWrite_o,
               IRWrite_o, RegWrite_o, RegDst_o, MemtoReg_o, PCSource_o,
               pc_en_o, illegal_o, state_o, retired_o
    );
endinterface

// File: rtl/mc_out_decode.sv
// ----------------------------------------------------------------------------
// mc_out_decode
// Combinational control-word decode for the multi-cycle controller.
//   state     : current controller state
//   op        : opcode in effect for this instruction
//   mem_ready : memory handshake (gates IRWrite/pc_en in FETCH)
//   zero      : ALU zero flag (gates pc_en in BRANCH)
//   ctrl      : full control word
// ----------------------------------------------------------------------------
module mc_out_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       mem_ready,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: full default first so no path through the case infers a latch.
        ctrl        = '0;
        // States that do not use the ALU still present a valid class, since
        // code 0 is reserved.
        ctrl.alu_op = ALUOP_ADD;

        unique case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut.
                ctrl.alu_src_b = SRCB_IMM_SH;
                unique case (op)
                    OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTIU,
                    OP_ORI, OP_LUI, OP_LW, OP_SW: ctrl.illegal = 1'b0;
                    default:                      ctrl.illegal = 1'b1;
                endcase
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.memto_reg = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_R;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                unique case (op)
                    OP_SLTIU: ctrl.alu_op = ALUOP_SLTIU;
                    OP_ORI:   ctrl.alu_op = ALUOP_ORI;
                    OP_LUI:   ctrl.alu_op = ALUOP_LUI;
                    default:  ctrl.alu_op = ALUOP_ADD;
                endcase
            end
            I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.pc_source = PCSRC_ALUOUT;
                if (op == OP_BNE) begin
                    ctrl.alu_op = ALUOP_BNE;
                    ctrl.pc_en  = ~zero;
                end else begin
                    ctrl.alu_op = ALUOP_BEQ;
                    ctrl.pc_en  = zero;
                end
            end
            JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_en     = 1'b1;
            end
            default: ctrl = ctrl;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle main controller: FETCH -> DECODE -> execute/memory/writeback,
// stalling on the memory ready handshake.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : mc_ctrl_fsm_if.master (opcode/ready/zero in, control word,
//           debug state and retired-instruction counter out)
// ----------------------------------------------------------------------------
module mc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mc_ctrl_fsm_if.master bus
);

    state_t              state;
    state_t              state_next;
    logic [5:0]          op_q;
    logic [5:0]          op_cur;
    logic [RETIRE_W-1:0] retired;
    ctrl_t               ctrl;

    // State register and retired counter.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst_i) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            state <= state_next;
            if (is_retiring(state) && (state_next == FETCH))
                retired <= retired + RETIRE_W'(1);
        end
    end

    // The opcode is captured in DECODE so later states do not depend on the
    // instruction register holding still.
    // NOTE: no reset needed; op_q is only read in states entered via DECODE.
    always_ff @(posedge clk_i) begin
        if (state == DECODE)
            op_q <= bus.instr_op_i;
    end

    assign op_cur = (state == DECODE) ? bus.instr_op_i : op_q;

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            FETCH:     if (bus.mem_ready_i) state_next = DECODE;
            DECODE: begin
                unique case (bus.instr_op_i)
                    OP_LW, OP_SW:                     state_next = MEM_ADDR;
                    OP_R:                             state_next = R_EXEC;
                    OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI: state_next = I_EXEC;
                    OP_BEQ, OP_BNE:                   state_next = BRANCH;
                    OP_J:                             state_next = JUMP;
                    default:                          state_next = FETCH;
                endcase
            end
            MEM_ADDR:  state_next = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (bus.mem_ready_i) state_next = MEM_WB;
            MEM_WRITE: if (bus.mem_ready_i) state_next = FETCH;
            R_EXEC:    state_next = R_WB;
            I_EXEC:    state_next = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_next = FETCH;
            default:   state_next = FETCH;
        endcase
    end

    mc_out_decode u_out_decode (
        .state     (state),
        .op        (op_cur),
        .mem_ready (bus.mem_ready_i),
        .zero      (bus.zero_i),
        .ctrl      (ctrl)
    );

    // Output drive; side-effecting strobes are held low during reset.
    always_comb begin
        bus.ALUOp_o    = ctrl.alu_op;
        bus.ALUSrcA_o  = ctrl.alu_src_a;
        bus.ALUSrcB_o  = ctrl.alu_src_b;
        bus.IorD_o     = ctrl.iord;
        bus.RegDst_o   = ctrl.reg_dst;
        bus.MemtoReg_o = ctrl.memto_reg;
        bus.PCSource_o = ctrl.pc_source;
        bus.MemRead_o  = ctrl.mem_read  & ~rst_i;
        bus.MemWrite_o = ctrl.mem_write & ~rst_i;
        bus.IRWrite_o  = ctrl.ir_write  & ~rst_i;
        bus.RegWrite_o = ctrl.reg_write & ~rst_i;
        bus.pc_en_o    = ctrl.pc_en     & ~rst_i;
        bus.illegal_o  = ctrl.illegal   & ~rst_i;
        bus.state_o    = state;
        bus.retired_o  = retired;
    end

endmodule
